// File: rtl/led_blinker_pkg.sv
// Shared constants and types for the LED blinker array controller.
package led_blinker_pkg;

    localparam logic [31:0] ADDR_TEST      = 32'h0000_0000;
    localparam logic [31:0] ADDR_MSG_COUNT = 32'h0000_0004;
    localparam logic [31:0] ADDR_STATUS    = 32'h0000_0008;
    localparam logic [31:0] ADDR_CH_BASE   = 32'h0000_0010;
    localparam logic [31:0] CH_STRIDE      = 32'h0000_0008;
    localparam logic [31:0] ADDR_MODE_OFS  = 32'h0000_0004;

    localparam logic [31:0] DEADBEEF       = 32'hDEAD_BEEF;

    localparam int unsigned STATUS_DONE_LSB = 8;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_LIT   = 2'd1,
        CH_BLINK = 2'd2,
        CH_BURST = 2'd3
    } ch_state_e;

    // MODE register payload as seen by a channel.
    typedef struct packed {
        logic [7:0] burst_n;
        mode_e      mode;
    } mode_reg_t;

endpackage

// File: rtl/led_blinker_channel.sv
// One LED channel: mode FSM, half-period counter and burst edge counter.
module led_blinker_channel
    import led_blinker_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 srst_i,
    input  logic                 mode_wr_i,
    input  mode_reg_t            mode_wdata_i,
    input  logic [CNT_WIDTH-1:0] period_i,
    output logic                 led_o,
    output logic                 done_c
);

    ch_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]           edges_q, edges_d;
    logic [7:0]           burst_n_q, burst_n_d;
    logic                 led_q, led_d;
    logic [CNT_WIDTH-1:0] last_cnt;
    logic                 term;

    // Terminal count; a zero period behaves as one, and a shrunk period wraps at once.
    assign last_cnt = (period_i == '0) ? '0 : period_i - CNT_WIDTH'(1);
    assign term     = (cnt_q >= last_cnt);

    // Next-state logic: a MODE write restarts the channel, otherwise run the current mode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        edges_d   = edges_q;
        burst_n_d = burst_n_q;
        led_d     = led_q;
        done_c    = 1'b0;
        if (mode_wr_i) begin
            cnt_d     = '0;
            edges_d   = '0;
            burst_n_d = mode_wdata_i.burst_n;
            unique case (mode_wdata_i.mode)
                MODE_OFF:   begin state_d = CH_IDLE;  led_d = 1'b0; end
                MODE_ON:    begin state_d = CH_LIT;   led_d = 1'b1; end
                MODE_BLINK: begin state_d = CH_BLINK; led_d = 1'b1; end
                MODE_BURST: begin
                    state_d = CH_BURST;
                    led_d   = (mode_wdata_i.burst_n != 8'd0);
                end
                default: ;
            endcase
        end else begin
            unique case (state_q)
                CH_IDLE: led_d = 1'b0;
                CH_LIT:  led_d = 1'b1;
                CH_BLINK: begin
                    if (term) begin
                        cnt_d = '0;
                        led_d = ~led_q;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                CH_BURST: begin
                    if (burst_n_q == 8'd0) begin
                        state_d = CH_IDLE;
                        led_d   = 1'b0;
                        done_c  = 1'b1;
                    end else if (term) begin
                        cnt_d = '0;
                        led_d = ~led_q;
                        if (led_q) begin
                            edges_d = edges_q + 8'd1;
                            if ((9'(edges_q) + 9'd1) == 9'(burst_n_q)) begin
                                state_d = CH_IDLE;
                                done_c  = 1'b1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Channel state registers with async and soft reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= CH_IDLE;
            cnt_q     <= '0;
            edges_q   <= '0;
            burst_n_q <= '0;
            led_q     <= 1'b0;
        end else if (srst_i) begin
            state_q   <= CH_IDLE;
            cnt_q     <= '0;
            edges_q   <= '0;
            burst_n_q <= '0;
            led_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edges_q   <= edges_d;
            burst_n_q <= burst_n_d;
            led_q     <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_blinker_array_ctrl.sv
// MM-slave LED blinker array: bus decode, shared registers, message counter.
module led_blinker_array_ctrl
    import led_blinker_pkg::*;
#(
    parameter int unsigned          NUM_LEDS       = 4,
    parameter int unsigned          CNT_WIDTH      = 26,
    parameter logic [CNT_WIDTH-1:0] DEFAULT_PERIOD = {CNT_WIDTH{1'b1}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         master_mm_address,
    input  logic                master_mm_read,
    input  logic                master_mm_write,
    input  logic [31:0]         master_mm_writedata,
    output logic [31:0]         master_mm_readdata,
    output logic                master_mm_readdatavalid,
    output logic                master_mm_waitrequest,
    input  logic                master_rst,
    input  logic                msg_enter,
    output logic [NUM_LEDS-1:0] led_active
);

    logic [31:0]          test_q, test_d;
    logic [31:0]          msg_cnt_q, msg_cnt_d;
    logic [NUM_LEDS-1:0]  done_q, done_d;
    logic [CNT_WIDTH-1:0] period_q [NUM_LEDS];
    logic [CNT_WIDTH-1:0] period_d [NUM_LEDS];
    mode_reg_t            mode_q   [NUM_LEDS];
    mode_reg_t            mode_d   [NUM_LEDS];
    logic                 wait_q;
    logic                 rvalid_q, rvalid_d;
    logic [31:0]          rdata_q, rdata_d;

    logic                 wr_en, rd_en;
    logic [NUM_LEDS-1:0]  sel_period, sel_mode, mode_wr, done_c;
    logic [NUM_LEDS-1:0]  led_w;
    logic [31:0]          status_w, rdata_mux;
    mode_reg_t            mode_wdata;

    // The bus is only accepted once the post-reset stall cycle is over.
    assign wr_en = master_mm_write & ~wait_q;
    assign rd_en = master_mm_read  & ~wait_q;

    assign mode_wdata = '{burst_n: master_mm_writedata[15:8],
                          mode:    mode_e'(master_mm_writedata[1:0])};

    // Per-channel address decode and channel instances.
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        assign sel_period[i] = (master_mm_address == ADDR_CH_BASE + 32'(i) * CH_STRIDE);
        assign sel_mode[i]   = (master_mm_address == ADDR_CH_BASE + 32'(i) * CH_STRIDE + ADDR_MODE_OFS);
        assign mode_wr[i]    = wr_en & sel_mode[i];

        led_blinker_channel #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .srst_i       (master_rst),
            .mode_wr_i    (mode_wr[i]),
            .mode_wdata_i (mode_wdata),
            .period_i     (period_q[i]),
            .led_o        (led_w[i]),
            .done_c       (done_c[i])
        );
    end

    // STATUS image and read mux; unmapped offsets return the DEADBEEF marker.
    always_comb begin
        status_w  = '0;
        rdata_mux = DEADBEEF;
        for (int i = 0; i < NUM_LEDS; i++) begin
            status_w[i]                   = led_w[i];
            status_w[STATUS_DONE_LSB + i] = done_q[i];
        end
        if (master_mm_address == ADDR_TEST)      rdata_mux = test_q;
        if (master_mm_address == ADDR_MSG_COUNT) rdata_mux = msg_cnt_q;
        if (master_mm_address == ADDR_STATUS)    rdata_mux = status_w;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (sel_period[i]) rdata_mux = 32'(period_q[i]);
            if (sel_mode[i])   rdata_mux = 32'({mode_q[i].burst_n, 6'b0, mode_q[i].mode});
        end
    end

    // Register next values; a bus write beats a same-cycle hardware update.
    always_comb begin
        test_d    = test_q;
        msg_cnt_d = msg_enter ? msg_cnt_q + 32'd1 : msg_cnt_q;
        done_d    = done_q | done_c;
        period_d  = period_q;
        mode_d    = mode_q;
        rvalid_d  = rd_en;
        rdata_d   = rd_en ? rdata_mux : 32'd0;
        if (wr_en && (master_mm_address == ADDR_TEST)) test_d = master_mm_writedata;
        if (wr_en && (master_mm_address == ADDR_MSG_COUNT)) msg_cnt_d = msg_enter ? 32'd1 : 32'd0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (done_c[i]) mode_d[i].mode = MODE_OFF;
            if (wr_en && (master_mm_address == ADDR_STATUS))
                done_d[i] = done_q[i] & ~master_mm_writedata[STATUS_DONE_LSB + i];
            if (mode_wr[i]) mode_d[i] = mode_wdata;
            if (wr_en && sel_period[i]) period_d[i] = master_mm_writedata[CNT_WIDTH-1:0];
        end
    end

    // Shared register file with async reset and synchronous soft reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            test_q    <= '0;
            msg_cnt_q <= '0;
            done_q    <= '0;
            wait_q    <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                period_q[i] <= DEFAULT_PERIOD;
                mode_q[i]   <= '0;
            end
        end else if (master_rst) begin
            test_q    <= '0;
            msg_cnt_q <= '0;
            done_q    <= '0;
            wait_q    <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                period_q[i] <= DEFAULT_PERIOD;
                mode_q[i]   <= '0;
            end
        end else begin
            test_q    <= test_d;
            msg_cnt_q <= msg_cnt_d;
            done_q    <= done_d;
            wait_q    <= 1'b0;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            period_q  <= period_d;
            mode_q    <= mode_d;
        end
    end

    assign master_mm_readdata      = rdata_q;
    assign master_mm_readdatavalid = rvalid_q;
    assign master_mm_waitrequest   = wait_q;
    assign led_active              = led_w;

endmodule

// File: tb/tb_led_blinker_array_ctrl.sv
// Directed bench for led_blinker_array_ctrl.
module tb_led_blinker_array_ctrl;

    localparam int unsigned NUM_LEDS  = 4;
    localparam int unsigned CNT_WIDTH = 26;
    localparam logic [31:0] DEF_PER   = 32'h03FF_FFFF;

    logic                clk = 1'b0;
    logic                rst;
    logic [31:0]         addr;
    logic                rd, wr;
    logic [31:0]         wdata;
    logic [31:0]         rdata;
    logic                rvalid, waitreq;
    logic                mrst, msg;
    logic [NUM_LEDS-1:0] led;

    int n_cmp = 0;
    int n_err = 0;

    led_blinker_array_ctrl #(
        .NUM_LEDS  (NUM_LEDS),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .master_mm_address       (addr),
        .master_mm_read          (rd),
        .master_mm_write         (wr),
        .master_mm_writedata     (wdata),
        .master_mm_readdata      (rdata),
        .master_mm_readdatavalid (rvalid),
        .master_mm_waitrequest   (waitreq),
        .master_rst              (mrst),
        .msg_enter               (msg),
        .led_active              (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        chk("rvalid", 32'(rvalid), 32'd1);
        d = rdata;
    endtask

    logic [31:0] r;
    logic [6:0]  blink_exp;
    logic        prev;
    int          highs, rises;

    initial begin
        rst = 1'b0; addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0; mrst = 1'b0; msg = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_led",    32'(led),     32'd0);
        chk("rst_wait",   32'(waitreq), 32'd1);
        chk("rst_rvalid", 32'(rvalid),  32'd0);
        chk("rst_rdata",  rdata,        32'd0);
        rst = 1'b1;
        #1 chk("wait_first_cycle", 32'(waitreq), 32'd1);
        @(negedge clk);
        chk("wait_released", 32'(waitreq), 32'd0);

        bus_read(32'h00, r); chk("test_rst", r, 32'd0);
        bus_read(32'h04, r); chk("msg_rst", r, 32'd0);
        bus_read(32'h08, r); chk("status_rst", r, 32'd0);
        @(negedge clk);
        chk("rvalid_idle", 32'(rvalid), 32'd0);
        chk("rdata_idle",  rdata,       32'd0);
        chk("led_idle",    32'(led),    32'd0);

        // Scratch, unmapped offsets and PERIOD width
        bus_write(32'h00, 32'hA5A5_5A5A);
        bus_read(32'h00, r);  chk("test_rw", r, 32'hA5A5_5A5A);
        bus_read(32'h40, r);  chk("unmapped_40", r, 32'hDEAD_BEEF);
        bus_read(32'h0C, r);  chk("unmapped_0c", r, 32'hDEAD_BEEF);
        bus_write(32'h40, 32'h1234_5678);
        bus_read(32'h00, r);  chk("test_after_unmapped_wr", r, 32'hA5A5_5A5A);
        bus_read(32'h20, r);  chk("period2_default", r, DEF_PER);
        bus_write(32'h28, 32'hFFFF_FFFF);
        bus_read(32'h28, r);  chk("period3_mask", r, DEF_PER);

        // Back-to-back reads give back-to-back responses
        @(negedge clk); addr = 32'h00; rd = 1'b1;
        @(negedge clk); addr = 32'h40;
        chk("b2b_valid0", 32'(rvalid), 32'd1); chk("b2b_data0", rdata, 32'hA5A5_5A5A);
        @(negedge clk); rd = 1'b0;
        chk("b2b_valid1", 32'(rvalid), 32'd1); chk("b2b_data1", rdata, 32'hDEAD_BEEF);

        // BLINK on channel 0 with half-period 3
        bus_write(32'h10, 32'd3);
        bus_write(32'h14, 32'd2);
        blink_exp = 7'b1000111;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("blink_%0d", i), 32'(led[1:0]), 32'(blink_exp[i]));
            @(negedge clk);
        end

        // BURST of 3 on channel 1 with half-period 2
        bus_write(32'h18, 32'd2);
        bus_write(32'h1C, 32'h0303);
        highs = 0; rises = 0; prev = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (led[1]) highs++;
            if (led[1] && !prev) rises++;
            prev = led[1];
            @(negedge clk);
        end
        chk("burst_pulses", 32'(rises), 32'd3);
        chk("burst_lit_cycles", 32'(highs), 32'd6);
        bus_read(32'h08, r); chk("done1_set", 32'(r[9]), 32'd1);
        bus_read(32'h1C, r); chk("mode1_cleared", 32'(r[1:0]), 32'd0);
        chk("mode1_burst_n_kept", 32'(r[15:8]), 32'd3);
        bus_write(32'h08, 32'h200);
        bus_read(32'h08, r); chk("done1_w1c", 32'(r[9]), 32'd0);

        // BURST with N=0 never lights and completes at once
        bus_write(32'h24, 32'h0003);
        chk("burst0_led_a", 32'(led[2]), 32'd0);
        @(negedge clk);
        chk("burst0_led_b", 32'(led[2]), 32'd0);
        bus_read(32'h08, r); chk("done2_set", 32'(r[10]), 32'd1);
        bus_read(32'h24, r); chk("mode2_cleared", 32'(r[1:0]), 32'd0);

        // ON and OFF
        bus_write(32'h2C, 32'd1); chk("on_led", 32'(led[3]), 32'd1);
        bus_write(32'h2C, 32'd0); chk("off_led", 32'(led[3]), 32'd0);

        // MSG_COUNT
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); msg = 1'b1;
        end
        @(negedge clk); msg = 1'b0;
        bus_read(32'h04, r); chk("msg_5", r, 32'd5);
        @(negedge clk); addr = 32'h04; wdata = 32'h0; wr = 1'b1; msg = 1'b1;
        @(negedge clk); wr = 1'b0; msg = 1'b0;
        bus_read(32'h04, r); chk("msg_clear_and_event", r, 32'd1);
        @(negedge clk); force dut.msg_cnt_d = 32'hFFFF_FFFF;
        @(negedge clk); release dut.msg_cnt_d;
        bus_read(32'h04, r); chk("msg_preload", r, 32'hFFFF_FFFF);
        @(negedge clk); msg = 1'b1;
        @(negedge clk); msg = 1'b0;
        bus_read(32'h04, r); chk("msg_wrap", r, 32'd0);

        // Soft reset while channel 0 blinks
        bus_write(32'h14, 32'd2);
        repeat (2) @(negedge clk);
        mrst = 1'b1;
        @(negedge clk); mrst = 1'b0;
        chk("mrst_led",  32'(led),     32'd0);
        chk("mrst_wait", 32'(waitreq), 32'd1);
        @(negedge clk);
        chk("mrst_wait_release", 32'(waitreq), 32'd0);
        bus_read(32'h10, r); chk("mrst_period0", r, DEF_PER);
        bus_read(32'h00, r); chk("mrst_test", r, 32'd0);
        bus_read(32'h14, r); chk("mrst_mode0", r, 32'd0);

        // Asynchronous reset mid-burst
        bus_write(32'h18, 32'd2);
        bus_write(32'h1C, 32'h0303);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_led",    32'(led),     32'd0);
        chk("arst_wait",   32'(waitreq), 32'd1);
        chk("arst_rvalid", 32'(rvalid),  32'd0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        repeat (12) @(negedge clk);
        bus_read(32'h08, r); chk("arst_status", r, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
